// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Branch prediction and resolution for a 5-stage RV32I pipeline.
//  * IF: direct-mapped BTB lookup. Each entry holds a 2-bit saturating
//    counter. The lookup yields pred_taken/pred_target.
//  * EX: resolves all six conditional branches from the raw operands, plus
//    JAL/JALR. It computes the correct next PC and flags a redirect when the
//    prediction carried down the pipe was wrong.
//  * Training: at the clock edge, resolved JAL and conditional branches
//    update or allocate their entry. JALR is never allocated.
//  * Statistics: saturating counters of resolved branches/jumps and of
//    redirects.
//
// Ports
//  clk, reset_n                  clock (rising edge), async active-low reset
//  if_pc                         fetch PC for the prediction lookup
//  pred_taken, pred_target       IF prediction (target is 0 when not taken)
//  ex_valid, ex_pc, ex_imm       EX instruction qualifier, PC, sign-ext imm
//  ex_rs1, ex_rs2                forwarded operands
//  ex_branch, ex_jal, ex_jalr    instruction class (jumps win over branch)
//  ex_funct3                     branch condition
//  ex_pred_taken/target          prediction that travelled with the instr
//  actual_taken                  resolved direction
//  redirect, redirect_pc         mispredict flush request and correct PC
//  pc_four                       ex_pc + 4 (link value)
//  stat_branches, stat_mispred   saturating statistics
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_valid,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [31:0]       ex_imm,
    input  logic [31:0]       ex_rs1,
    input  logic [31:0]       ex_rs2,
    input  logic              ex_branch,
    input  logic              ex_jal,
    input  logic              ex_jalr,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic              actual_taken,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic [31:0]       pc_four,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    // Table state, one field per array.
    logic [ENTRIES-1:0]             valid_q,  valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q,    tag_d;
    logic [ENTRIES-1:0]             jump_q,   jump_d;
    logic [ENTRIES-1:0][1:0]        ctr_q,    ctr_d;
    logic [ENTRIES-1:0][31:0]       target_q, target_d;
    logic [STAT_W-1:0]              stat_branches_q, stat_branches_d;
    logic [STAT_W-1:0]              stat_mispred_q,  stat_mispred_d;

    // ---------------- IF lookup ----------------
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic             unused_pc_lsbs;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[PC_W-1:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    // IF reads only the registered table, so a write to the same index in
    // this cycle is not visible until the next one.
    assign pred_taken  = if_hit && (jump_q[if_idx] || ctr_q[if_idx][1]);
    assign pred_target = pred_taken ? target_q[if_idx] : 32'd0;
    // Instructions are word aligned; the low PC bits play no part in lookup.
    assign unused_pc_lsbs = &{1'b0, if_pc[1:0]};

    // ---------------- EX resolution ----------------
    logic [31:0]      pc32;
    logic [31:0]      ex_target;
    logic             cond;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;

    assign pc32    = 32'(ex_pc);
    assign pc_four = pc32 + 32'd4;
    assign ex_idx  = ex_pc[IDX_W+1:2];
    assign ex_tag  = ex_pc[PC_W-1:IDX_W+2];
    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        cond = 1'b0;
        unique case (ex_funct3)
            3'b000:  cond = (ex_rs1 == ex_rs2);
            3'b001:  cond = (ex_rs1 != ex_rs2);
            3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond = (ex_rs1 <  ex_rs2);
            3'b111:  cond = (ex_rs1 >= ex_rs2);
            default: cond = 1'b0;
        endcase
    end

    assign ex_target    = ex_jalr ? ((ex_rs1 + ex_imm) & ~32'd1) : (pc32 + ex_imm);
    assign actual_taken = ex_valid && (ex_jal || ex_jalr || (ex_branch && cond));
    assign redirect     = ex_valid && ((actual_taken != ex_pred_taken) ||
                          (actual_taken && (ex_target != ex_pred_target)));
    assign redirect_pc  = !ex_valid    ? 32'd0 :
                          actual_taken ? ex_target : pc_four;

    // ---------------- Training and statistics ----------------
    always_comb begin
        valid_d         = valid_q;
        tag_d           = tag_q;
        jump_d          = jump_q;
        ctr_d           = ctr_q;
        target_d        = target_q;
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;

        // JALR targets are data dependent, so JALR never trains the table.
        if (ex_valid && !ex_jalr && (ex_branch || ex_jal)) begin
            if (actual_taken) begin
                target_d[ex_idx] = ex_target;
                jump_d[ex_idx]   = ex_jal;
                if (ex_hit) begin
                    if (ctr_q[ex_idx] != 2'b11)
                        ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
                end else begin
                    valid_d[ex_idx] = 1'b1;
                    tag_d[ex_idx]   = ex_tag;
                    ctr_d[ex_idx]   = 2'b10;
                end
            end else if (ex_hit && (ctr_q[ex_idx] != 2'b00)) begin
                ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
            end
        end

        if (ex_valid && (ex_branch || ex_jal || ex_jalr) && (stat_branches_q != '1))
            stat_branches_d = stat_branches_q + STAT_W'(1);
        if (redirect && (stat_mispred_q != '1))
            stat_mispred_d = stat_mispred_q + STAT_W'(1);
    end

    // NOTE: the table is small and must come out of reset with every entry
    // invalid and weakly not-taken, so every entry is reset rather than
    // inferring an unreset RAM. Sequential state uses non-blocking assignment
    // only, so all flops sample their _d values from the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q         <= '0;
            tag_q           <= '0;
            jump_q          <= '0;
            ctr_q           <= {ENTRIES{2'b01}};
            target_q        <= '0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            jump_q          <= jump_d;
            ctr_q           <= ctr_d;
            target_q        <= target_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
//
// Directed bench for branch_predict_unit. Each step drives the EX and IF
// inputs just after a rising edge. The step then queues the expected outputs
// and compares them on the following falling edge, before the edge that
// commits the step. Expected values are worked out by hand from the branch
// semantics. STAT_W is reduced to 8 so that saturation is reachable.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

    localparam int PC_W   = 9;
    localparam int STAT_W = 8;

    logic              clk;
    logic              reset_n;
    logic [PC_W-1:0]   if_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic [31:0]       ex_imm;
    logic [31:0]       ex_rs1;
    logic [31:0]       ex_rs2;
    logic              ex_branch;
    logic              ex_jal;
    logic              ex_jalr;
    logic [2:0]        ex_funct3;
    logic              ex_pred_taken;
    logic [31:0]       ex_pred_target;
    logic              actual_taken;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [31:0]       pc_four;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispred;

    branch_predict_unit #(.PC_W(PC_W), .ENTRIES(16), .STAT_W(STAT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_branch      (ex_branch),
        .ex_jal         (ex_jal),
        .ex_jalr        (ex_jalr),
        .ex_funct3      (ex_funct3),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .actual_taken   (actual_taken),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .pc_four        (pc_four),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {O_PT, O_PTGT, O_AT, O_RD, O_RPC, O_P4, O_SB, O_SM} obs_e;
    typedef struct {
        obs_e        sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(input obs_e s);
        case (s)
            O_PT:    return 32'(pred_taken);
            O_PTGT:  return pred_target;
            O_AT:    return 32'(actual_taken);
            O_RD:    return 32'(redirect);
            O_RPC:   return redirect_pc;
            O_P4:    return pc_four;
            O_SB:    return 32'(stat_branches);
            default: return 32'(stat_mispred);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic push(input obs_e s, input logic [31:0] v, input string n);
        exp_t e;
        e.sel  = s;
        e.val  = v;
        e.name = n;
        sb_q.push_back(e);
    endtask

    // The outputs are settled by the falling edge; compare everything queued.
    task automatic drain();
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, observe(e.sel), e.val);
        end
    endtask

    task automatic next_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [PC_W-1:0] pc, input logic [31:0] imm,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic br, input logic jal, input logic jalr,
                            input logic [2:0] f3, input logic pt, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_pc          = pc;
        ex_imm         = imm;
        ex_rs1         = rs1;
        ex_rs2         = rs2;
        ex_branch      = br;
        ex_jal         = jal;
        ex_jalr        = jalr;
        ex_funct3      = f3;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    task automatic idle();
        drive_ex(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, '0);
    endtask

    task automatic exp_ex(input string n, input logic at, input logic rd, input logic [31:0] rpc);
        push(O_AT,  32'(at), {n, "_taken"});
        push(O_RD,  32'(rd), {n, "_redirect"});
        push(O_RPC, rpc,     {n, "_redirect_pc"});
    endtask

    task automatic exp_pred(input string n, input logic pt, input logic [31:0] tgt);
        push(O_PT,   32'(pt), {n, "_pred_taken"});
        push(O_PTGT, tgt,     {n, "_pred_target"});
    endtask

    task automatic exp_stats(input string n, input int b, input int m);
        push(O_SB, 32'(b), {n, "_stat_branches"});
        push(O_SM, 32'(m), {n, "_stat_mispred"});
    endtask

    initial begin
        // 1: reset state
        reset_n = 1'b0;
        if_pc   = 9'h040;
        idle();
        exp_pred("reset", 1'b0, 32'h0);
        exp_stats("reset", 0, 0);
        push(O_RD, 32'h0, "reset_redirect");
        drain();
        reset_n = 1'b1;

        // 2: BEQ taken, predicted not taken -> allocate idx0 tag1 ctr=10
        next_step();
        drive_ex(1'b1, 9'h040, 32'h20, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
        exp_ex("beq_first", 1'b1, 1'b1, 32'h060);
        push(O_P4, 32'h044, "beq_first_pc_four");
        exp_pred("beq_first_no_bypass", 1'b0, 32'h0);
        drain();

        next_step();
        idle();
        exp_pred("beq_learned", 1'b1, 32'h060);
        exp_stats("beq_learned", 1, 1);
        drain();

        // 3: three correctly predicted taken BEQs, ctr 10 -> 11 -> 11 -> 11
        for (int i = 0; i < 3; i++) begin
            next_step();
            drive_ex(1'b1, 9'h040, 32'h20, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 32'h060);
            exp_ex("beq_correct", 1'b1, 1'b0, 32'h060);
            exp_pred("beq_correct", 1'b1, 32'h060);
            drain();
        end

        // Not taken, predicted taken: ctr 11 -> 10, still predicts taken
        next_step();
        drive_ex(1'b1, 9'h040, 32'h20, 32'd5, 32'd6, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 32'h060);
        exp_ex("beq_nt1", 1'b0, 1'b1, 32'h044);
        exp_stats("beq_nt1", 4, 1);
        drain();

        next_step();
        drive_ex(1'b1, 9'h040, 32'h20, 32'd5, 32'd6, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 32'h060);
        exp_ex("beq_nt2", 1'b0, 1'b1, 32'h044);
        exp_pred("beq_nt2_ctr10", 1'b1, 32'h060);
        drain();

        next_step();
        idle();
        exp_pred("beq_ctr01", 1'b0, 32'h0);
        exp_stats("beq_ctr01", 6, 3);
        drain();

        // 4: condition decode at pc=0x104 (idx1 tag4), rs1=-1 rs2=1
        if_pc = 9'h104;
        next_step();
        drive_ex(1'b1, 9'h104, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 32'h0);
        exp_ex("bltu", 1'b0, 1'b0, 32'h108);
        drain();

        next_step();
        drive_ex(1'b1, 9'h104, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 32'h0);
        exp_ex("blt", 1'b1, 1'b1, 32'h114);
        exp_pred("blt_miss", 1'b0, 32'h0);
        drain();

        next_step();
        drive_ex(1'b1, 9'h104, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 32'h0);
        exp_ex("bgeu", 1'b1, 1'b1, 32'h114);
        exp_pred("bgeu_hit", 1'b1, 32'h114);
        drain();

        next_step();
        drive_ex(1'b1, 9'h104, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 32'h0);
        exp_ex("bge", 1'b0, 1'b0, 32'h108);
        drain();

        next_step();
        drive_ex(1'b1, 9'h104, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 32'h114);
        exp_ex("bne", 1'b1, 1'b0, 32'h114);
        drain();

        next_step();
        drive_ex(1'b1, 9'h104, 32'h10, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 32'h0);
        exp_ex("f3_010", 1'b0, 1'b0, 32'h108);
        drain();

        // Predicted taken with the wrong target still redirects
        next_step();
        drive_ex(1'b1, 9'h104, 32'h10, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 32'h200);
        exp_ex("bad_target", 1'b1, 1'b1, 32'h114);
        exp_stats("bad_target", 12, 5);
        drain();

        next_step();
        idle();
        exp_pred("blt_entry", 1'b1, 32'h114);
        exp_stats("blt_entry", 13, 6);
        drain();

        // 5: JALR target clears bit 0 and is never allocated
        if_pc = 9'h080;
        next_step();
        drive_ex(1'b1, 9'h080, 32'd2, 32'h101, 32'h0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0);
        exp_ex("jalr", 1'b1, 1'b1, 32'h102);
        push(O_P4, 32'h084, "jalr_pc_four");
        drain();

        next_step();
        idle();
        exp_pred("jalr_no_alloc", 1'b0, 32'h0);
        drain();

        next_step();
        drive_ex(1'b1, 9'h080, 32'd2, 32'h101, 32'h0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h102);
        exp_ex("jalr_predicted", 1'b1, 1'b0, 32'h102);
        drain();

        // JAL with a negative immediate and ex_branch also set (jump wins)
        if_pc = 9'h0C0;
        next_step();
        drive_ex(1'b1, 9'h0C0, 32'hFFFF_FFC0, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 32'h0);
        exp_ex("jal", 1'b1, 1'b1, 32'h080);
        push(O_P4, 32'h0C4, "jal_pc_four");
        drain();

        next_step();
        idle();
        exp_pred("jal_entry", 1'b1, 32'h080);
        exp_stats("jal_entry", 16, 8);
        drain();

        // 6: bubble with a taken-looking branch that would overwrite idx0
        next_step();
        drive_ex(1'b0, 9'h140, 32'h10, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
        exp_ex("bubble", 1'b0, 1'b0, 32'h0);
        drain();

        next_step();
        idle();
        exp_pred("bubble_no_update", 1'b1, 32'h080);
        exp_stats("bubble_hold", 16, 8);
        drain();

        // Drive far more mispredicting JALRs than the counters can hold
        for (int i = 0; i < 250; i++) begin
            next_step();
            drive_ex(1'b1, 9'h080, 32'd2, 32'h101, 32'h0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0);
        end
        next_step();
        idle();
        exp_stats("saturated", 255, 255);
        drain();

        // Mid-run reset together with a taken branch to pc=0x140
        next_step();
        drive_ex(1'b1, 9'h140, 32'h10, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
        reset_n = 1'b0;
        exp_pred("midreset", 1'b0, 32'h0);
        exp_stats("midreset", 0, 0);
        drain();

        next_step();
        reset_n = 1'b1;
        idle();
        if_pc = 9'h140;
        exp_pred("midreset_no_commit", 1'b0, 32'h0);
        exp_stats("midreset_after", 0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
